// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: controller state
// encoding, the end-of-program marker and the word geometry of the byte stream.
package instr_mem_loader_pkg;

  // Controller states: waiting for a load, receiving bytes, and the single
  // wrap-up cycle that announces the end of a load.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  // A program ends with this word. It is written to memory like any other word.
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Memory is byte addressed, so consecutive words sit 4 addresses apart.
  localparam int WORD_STRIDE = 4;

  // Number of stream bytes that make up one instruction word.
  localparam int BYTES_PER_WORD = 4;

  // True when the byte being accepted now is the last byte of a word.
  function automatic logic is_last_byte(input logic [1:0] count);
    return count == 2'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Assembles 32-bit words from a byte stream, most significant byte first.
// The first three bytes are held in a shift register; the fourth byte is
// combined with them on the fly, so the finished word and its valid strobe
// appear in the same cycle as the fourth byte. The owner registers the word.
module word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift_q;
  logic [1:0]  count_q;

  // Shift accepted bytes in and count them; the 2-bit count wraps after the
  // fourth byte, so the next byte always starts a fresh word. A clear or a
  // reset throws away any partially assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_in};
      count_q <= count_q + 2'd1;
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_valid && is_last_byte(count_q);

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader. Receives a program as a byte stream from the
// debug unit, packs it into words and writes them to instruction memory from
// address 0 upward until the halt word arrives or memory runs out.
// While a load is in progress the loader owns the memory port and holds the
// pipeline stalled; otherwise the memory address comes straight from the
// fetch PC through a combinational mux, so fetch sees no added latency.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 60,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load_start,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_rx_valid,
  input  logic [NBITS-1:0] i_cpu_pc,
  output logic [NBITS-1:0] o_mem_addr,
  output logic [NBITS-1:0] o_mem_wdata,
  output logic             o_mem_we,
  output logic             o_cpu_stall,
  output logic             o_busy,
  output logic             o_load_done,
  output logic             o_err_overflow,
  output logic [NBITS-1:0] o_words_loaded
);

  // Highest address that can still take a full word, and the address step.
  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - WORD_STRIDE);
  localparam logic [NBITS-1:0] STRIDE    = NBITS'(WORD_STRIDE);

  loader_state_t    state;
  loader_state_t    state_next;

  logic [NBITS-1:0] load_addr;
  logic [NBITS-1:0] words_loaded;
  logic [NBITS-1:0] mem_wdata;
  logic             mem_we;
  logic             err_overflow;

  logic             start_load;
  logic             byte_accept;
  logic [31:0]      packed_word;
  logic             word_valid;
  logic             word_fits;
  logic             word_is_halt;
  logic             write_word;
  logic             drop_word;

  // A start pulse only counts when no load is running; bytes only count
  // while receiving. Everything else on these inputs is ignored.
  assign start_load  = (state == ST_IDLE) && i_load_start;
  assign byte_accept = (state == ST_RECV) && i_rx_valid;

  // A completed word is written if it still fits in memory, otherwise it is
  // dropped and the load is cut short with the overflow flag raised.
  assign word_fits    = (load_addr <= LAST_ADDR);
  assign word_is_halt = (NBITS'(packed_word) == HALT_WORD);
  assign write_word   = word_valid && word_fits;
  assign drop_word    = word_valid && !word_fits;

  word_packer u_word_packer (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .clear      (start_load),
    .byte_in    (i_rx_byte),
    .byte_valid (byte_accept),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  // Controller state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a load ends on the word that carries the halt marker (that
  // word is still written, during the DONE cycle) or on the first word that
  // no longer fits. DONE always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_load) begin
          state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        if (drop_word || (write_word && word_is_halt)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Register each completed word and raise a one-cycle write pulse for it,
  // one cycle after its last byte arrived.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= write_word;
      if (write_word) begin
        mem_wdata <= NBITS'(packed_word);
      end
    end
  end

  // The load address and word count advance at the end of each write cycle,
  // so the address stays stable while the write is on the bus. Starting a
  // new load rewinds both.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      load_addr    <= '0;
      words_loaded <= '0;
    end else if (start_load) begin
      load_addr    <= '0;
      words_loaded <= '0;
    end else if (mem_we) begin
      load_addr    <= load_addr + STRIDE;
      words_loaded <= words_loaded + NBITS'(1);
    end
  end

  // Sticky overflow flag: set when a word is dropped, cleared only by the
  // start of the next load or by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_overflow <= 1'b0;
    end else if (start_load) begin
      err_overflow <= 1'b0;
    end else if (drop_word) begin
      err_overflow <= 1'b1;
    end
  end

  assign o_mem_addr     = (state == ST_IDLE) ? i_cpu_pc : load_addr;
  assign o_mem_wdata    = mem_wdata;
  assign o_mem_we       = mem_we;
  assign o_cpu_stall    = (state != ST_IDLE);
  assign o_busy         = (state == ST_RECV);
  assign o_load_done    = (state == ST_DONE);
  assign o_err_overflow = err_overflow;
  assign o_words_loaded = words_loaded;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader. Expected memory writes are queued
// as bytes are sent and matched against every write pulse the loader makes.
module tb_instr_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [31:0] cpu_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_stall;
  logic        busy;
  logic        load_done;
  logic        err_overflow;
  logic [31:0] words_loaded;

  logic [63:0] exp_q[$];
  int          n_compared;
  int          n_mismatched;
  int          done_count;
  int          stall_drops;
  bit          in_load;

  instr_mem_loader #(
    .NBITS  (32),
    .CELDAS (60)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_load_start   (load_start),
    .i_rx_byte      (rx_byte),
    .i_rx_valid     (rx_valid),
    .i_cpu_pc       (cpu_pc),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_we       (mem_we),
    .o_cpu_stall    (cpu_stall),
    .o_busy         (busy),
    .o_load_done    (load_done),
    .o_err_overflow (err_overflow),
    .o_words_loaded (words_loaded)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one stream byte for a single cycle, after an optional idle gap.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulseStart();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Send a word MSB first; queue the write it should produce, if any.
  task automatic sendWord(input logic [31:0] w, input int gap, input bit expect_write,
                          input logic [31:0] addr);
    if (expect_write) exp_q.push_back({addr, w});
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(w[8*i +: 8], gap);
    end
  endtask

  // Called in the DONE cycle of a load that ended on its last sent word.
  task automatic checkLoadEnd(input string name, input logic [31:0] exp_words,
                              input logic exp_err);
    @(negedge clk);
    checkOutput({name, "_done"}, 32'(load_done), 32'd1);
    checkOutput({name, "_done_stall"}, 32'(cpu_stall), 32'd1);
    checkOutput({name, "_done_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_err"}, 32'(err_overflow), 32'(exp_err));
    in_load = 1'b0;
    @(negedge clk);
    checkOutput({name, "_done_gone"}, 32'(load_done), 32'd0);
    checkOutput({name, "_stall_off"}, 32'(cpu_stall), 32'd0);
    checkOutput({name, "_words"}, words_loaded, exp_words);
    checkOutput({name, "_err_sticky"}, 32'(err_overflow), 32'(exp_err));
    checkOutput({name, "_addr_pc"}, mem_addr, cpu_pc);
    tick();
  endtask

  // Scoreboard: every write pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_we", 32'(mem_we), 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          checkOutput("wr_addr", mem_addr, e[63:32]);
          checkOutput("wr_data", mem_wdata, e[31:0]);
        end
      end
      if (load_done) done_count++;
      if (in_load && !cpu_stall) stall_drops++;
    end
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    done_count   = 0;
    stall_drops  = 0;
    in_load      = 1'b0;
    rst_n        = 1'b0;
    load_start   = 1'b0;
    rx_byte      = 8'h00;
    rx_valid     = 1'b0;
    cpu_pc       = 32'h0000_0100;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_err", 32'(err_overflow), 32'd0);
    checkOutput("rst_words", words_loaded, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_addr_pc", mem_addr, 32'h0000_0100);
    tick();

    // 1: one word plus halt, with gaps between bytes.
    pulseStart();
    @(negedge clk);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_stall", 32'(cpu_stall), 32'd1);
    checkOutput("t1_addr_loader", mem_addr, 32'd0);
    tick();
    in_load = 1'b1;
    sendWord(32'h0000_0820, 1, 1'b1, 32'd0);
    sendWord(HALT, 0, 1'b1, 32'd4);
    checkLoadEnd("t1", 32'd2, 1'b0);

    // 2: back-to-back bytes, three words plus halt.
    pulseStart();
    in_load = 1'b1;
    sendWord(32'h1122_3344, 0, 1'b1, 32'd0);
    sendWord(32'h5566_7788, 0, 1'b1, 32'd4);
    sendWord(32'h99AA_BBCC, 0, 1'b1, 32'd8);
    sendWord(HALT, 0, 1'b1, 32'd12);
    checkLoadEnd("t2", 32'd4, 1'b0);

    // 3: sixteen words into a 15-word memory.
    pulseStart();
    in_load = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sendWord(32'h10 + 32'(i) * 32'h0101_0101, i % 2, (i < 15), 32'(i) * 32'd4);
    end
    checkLoadEnd("t3", 32'd15, 1'b1);
    pulseStart();
    @(negedge clk);
    checkOutput("t3_err_cleared", 32'(err_overflow), 32'd0);
    checkOutput("t3_words_cleared", words_loaded, 32'd0);
    checkOutput("t3_restart_addr", mem_addr, 32'd0);
    tick();

    // 4a: reset while a write pulse is on the bus.
    cpu_pc = 32'h0000_0200;
    sendWord(32'hCAFE_0001, 0, 1'b1, 32'd0);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("t4_we_async", 32'(mem_we), 32'd0);
    checkOutput("t4_stall_async", 32'(cpu_stall), 32'd0);
    checkOutput("t4_addr_pc", mem_addr, 32'h0000_0200);
    checkOutput("t4_words_rst", words_loaded, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 4b: reset with a partial word pending, then a clean load.
    pulseStart();
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_partial_stall", 32'(cpu_stall), 32'd0);
    checkOutput("t4_partial_addr", mem_addr, 32'h0000_0200);
    tick();
    rst_n = 1'b1;
    tick();
    pulseStart();
    in_load = 1'b1;
    sendWord(32'h0123_4567, 0, 1'b1, 32'd0);
    sendWord(HALT, 0, 1'b1, 32'd4);
    checkLoadEnd("t4", 32'd2, 1'b0);

    // 5: bytes in IDLE are ignored and the PC drives the address.
    cpu_pc = 32'h0000_0014;
    for (int i = 0; i < 6; i++) begin
      rx_byte  = 8'hD0 + 8'(i);
      rx_valid = 1'b1;
      @(negedge clk);
      checkOutput("t5_idle_addr", mem_addr, 32'h0000_0014);
      checkOutput("t5_idle_busy", 32'(busy), 32'd0);
      tick();
    end
    rx_valid = 1'b0;

    // 5: start pulses during RECV do not disturb bytes or addresses.
    pulseStart();
    in_load = 1'b1;
    exp_q.push_back({32'd0, 32'h0A0B_0C0D});
    applyStimulus(8'h0A, 0);
    applyStimulus(8'h0B, 0);
    pulseStart();
    applyStimulus(8'h0C, 0);
    applyStimulus(8'h0D, 0);
    pulseStart();
    sendWord(32'h1A1B_1C1D, 0, 1'b1, 32'd4);
    sendWord(HALT, 0, 1'b1, 32'd8);
    checkLoadEnd("t5", 32'd3, 1'b0);

    repeat (2) tick();
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("done_pulses", 32'(done_count), 32'd5);
    checkOutput("stall_held", 32'(stall_drops), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
